// File: rtl/timing_loop_ctrl.sv
// Symbol-timing loop sequencer: IDLE -> CLEAR -> ACQ (wide gains) -> TRACK (narrow gains).
// Lock is judged from the mean |TED error| over fixed windows of LOCK_WIN valid errors;
// loss of lock or an acquisition timeout sends the loop back through CLEAR.
module timing_loop_ctrl #(
   parameter int WERR         = 18,
   parameter int ACQ_KP_SHIFT = 5,
   parameter int ACQ_KI_SHIFT = 9,
   parameter int TRK_KP_SHIFT = 7,
   parameter int TRK_KI_SHIFT = 12,
   parameter int LOCK_WIN     = 64,
   parameter int LOCK_THR     = 1024,
   parameter int UNLOCK_THR   = 4096,
   parameter int LOCK_CNT     = 4,
   parameter int UNLOCK_CNT   = 2,
   parameter int ACQ_SYMS     = 256,
   parameter int TIMEOUT_SYMS = 8192,
   parameter int CLR_CYC      = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable_i,
   input  logic [WERR-1:0] e_in_i,
   input  logic            e_valid_i,
   output logic [4:0]      kp_shift_o,
   output logic [4:0]      ki_shift_o,
   output logic            loop_clr_o,
   output logic [1:0]      state_o,
   output logic            locked_o,
   output logic            lock_lost_o,
   output logic            acq_timeout_o,
   output logic [WERR-1:0] err_avg_o
);

   localparam int LW  = $clog2(LOCK_WIN);
   localparam int AW  = WERR - 1 + LW;            // sum of LOCK_WIN magnitudes never overflows
   localparam int WCW = (LW > 0) ? LW : 1;
   localparam int ACW = $clog2(TIMEOUT_SYMS + 1);
   localparam int GCW = $clog2(LOCK_CNT + 1);
   localparam int BCW = $clog2(UNLOCK_CNT + 1);
   localparam int CCW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

   localparam logic [WERR-1:0] MIN_NEG      = {1'b1, {(WERR-1){1'b0}}};
   localparam logic [WERR-1:0] LOCK_THR_V   = WERR'(LOCK_THR);
   localparam logic [WERR-1:0] UNLOCK_THR_V = WERR'(UNLOCK_THR);
   localparam logic [WCW-1:0]  WIN_LAST     = WCW'(LOCK_WIN - 1);
   localparam logic [ACW-1:0]  TO_V         = ACW'(TIMEOUT_SYMS);
   localparam logic [ACW-1:0]  ACQ_SYMS_V   = ACW'(ACQ_SYMS);
   localparam logic [GCW-1:0]  LOCK_CNT_V   = GCW'(LOCK_CNT);
   localparam logic [BCW-1:0]  UNLOCK_CNT_V = BCW'(UNLOCK_CNT);
   localparam logic [CCW-1:0]  CLR_LAST     = CCW'(CLR_CYC - 1);
   localparam logic [4:0]      ACQ_KP       = 5'(ACQ_KP_SHIFT);
   localparam logic [4:0]      ACQ_KI       = 5'(ACQ_KI_SHIFT);
   localparam logic [4:0]      TRK_KP       = 5'(TRK_KP_SHIFT);
   localparam logic [4:0]      TRK_KI       = 5'(TRK_KI_SHIFT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_ACQ   = 2'd2,
      S_TRACK = 2'd3
   } state_t;

   state_t          state, nxt_state;
   logic [CCW-1:0]  clr_cnt;
   logic [WCW-1:0]  win_cnt;
   logic [AW-1:0]   acc;
   logic [ACW-1:0]  acq_cnt, acq_nxt;
   logic [GCW-1:0]  good_cnt, good_nxt;
   logic [BCW-1:0]  bad_cnt, bad_nxt;
   logic [WERR-2:0] mag;
   logic [AW-1:0]   sum;
   logic [WERR-1:0] mean;
   logic            run, win_end, lock_go, tmo_go, unlock_go;

   // Error magnitude, window mean and the lock/unlock/timeout decisions for this cycle
   always_comb begin
      mag = '0;
      if (e_in_i[WERR-1]) begin
         if (e_in_i == MIN_NEG) mag = '1;          // -2^(WERR-1) saturates instead of wrapping
         else                   mag = (WERR-1)'(-e_in_i);
      end else begin
         mag = e_in_i[WERR-2:0];
      end
      sum       = acc + AW'(mag);
      mean      = WERR'(sum >> LW);
      run       = (state == S_ACQ) || (state == S_TRACK);
      win_end   = e_valid_i && run && (win_cnt == WIN_LAST);
      acq_nxt   = (acq_cnt == TO_V) ? acq_cnt : acq_cnt + 1'b1;
      good_nxt  = (mean < LOCK_THR_V) ?
                  ((good_cnt == LOCK_CNT_V) ? good_cnt : good_cnt + 1'b1) : '0;
      bad_nxt   = (mean > UNLOCK_THR_V) ?
                  ((bad_cnt == UNLOCK_CNT_V) ? bad_cnt : bad_cnt + 1'b1) : '0;
      lock_go   = win_end && (good_nxt >= LOCK_CNT_V) && (acq_nxt >= ACQ_SYMS_V);
      tmo_go    = e_valid_i && (acq_nxt == TO_V);
      unlock_go = win_end && (bad_nxt >= UNLOCK_CNT_V);
   end

   // Next-state selection; a lock decision outranks a timeout on the same error
   always_comb begin
      nxt_state = state;
      case (state)
         S_IDLE:  nxt_state = S_CLEAR;
         S_CLEAR: if (clr_cnt == CLR_LAST) nxt_state = S_ACQ;
         S_ACQ: begin
            if (lock_go)     nxt_state = S_TRACK;
            else if (tmo_go) nxt_state = S_CLEAR;
         end
         S_TRACK: if (unlock_go) nxt_state = S_CLEAR;
         default: nxt_state = S_IDLE;
      endcase
   end

   // Sequencer state, window metric and registered outputs; disable behaves like reset
   always_ff @(posedge clk) begin
      if (rst || !enable_i) begin
         state         <= S_IDLE;
         clr_cnt       <= '0;
         win_cnt       <= '0;
         acc           <= '0;
         acq_cnt       <= '0;
         good_cnt      <= '0;
         bad_cnt       <= '0;
         loop_clr_o    <= 1'b1;
         kp_shift_o    <= ACQ_KP;
         ki_shift_o    <= ACQ_KI;
         locked_o      <= 1'b0;
         lock_lost_o   <= 1'b0;
         acq_timeout_o <= 1'b0;
         err_avg_o     <= '0;
      end else begin
         state <= nxt_state;
         if (nxt_state != state) begin
            // every state entry starts from a clean metric
            clr_cnt  <= '0;
            win_cnt  <= '0;
            acc      <= '0;
            acq_cnt  <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
         end else begin
            if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
            if (e_valid_i && run) begin
               if (win_end) begin
                  acc      <= '0;
                  win_cnt  <= '0;
                  good_cnt <= good_nxt;
                  bad_cnt  <= bad_nxt;
               end else begin
                  acc      <= sum;
                  win_cnt  <= win_cnt + 1'b1;
               end
               if (state == S_ACQ) acq_cnt <= acq_nxt;
            end
         end
         if (win_end) err_avg_o <= mean;
         loop_clr_o    <= (nxt_state == S_IDLE) || (nxt_state == S_CLEAR);
         locked_o      <= (nxt_state == S_TRACK);
         kp_shift_o    <= (nxt_state == S_TRACK) ? TRK_KP : ACQ_KP;
         ki_shift_o    <= (nxt_state == S_TRACK) ? TRK_KI : ACQ_KI;
         acq_timeout_o <= (state == S_ACQ)   && (nxt_state == S_CLEAR);
         lock_lost_o   <= (state == S_TRACK) && (nxt_state == S_CLEAR);
      end
   end

   assign state_o = state;

endmodule
